// File: rtl/hdc_assoc_search_if.sv
// Bus bundle for the HDC associative search controller: start/busy, the shared
// query/class memory read port and the result valid/ready handshake.
interface hdc_assoc_search_if #(
    parameter int unsigned D           = 128,
    parameter int unsigned W           = 32,
    parameter int unsigned NUM_CLASSES = 4
);
    localparam int unsigned WORDS = D / W;
    localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CW    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int unsigned DW    = $clog2(D + 1);

    logic          start;
    logic          busy;
    logic          re;
    logic [AW-1:0] read_addr;
    logic [CW-1:0] class_sel;
    logic [W-1:0]  query_data;
    logic [W-1:0]  class_data;
    logic          result_valid;
    logic          result_ready;
    logic [CW-1:0] result_class;
    logic [DW-1:0] result_dist;

    // master: requester plus the memories; slave: the search engine
    modport master (
        output start, query_data, class_data, result_ready,
        input  busy, re, read_addr, class_sel, result_valid, result_class, result_dist
    );

    modport slave (
        input  start, query_data, class_data, result_ready,
        output busy, re, read_addr, class_sel, result_valid, result_class, result_dist
    );
endinterface

// File: rtl/hdc_assoc_search.sv
// Associative-memory search: streams the query and each class hypervector W bits
// per cycle, accumulates Hamming distance and returns the minimum-distance class.
module hdc_assoc_search #(
    parameter int unsigned D           = 128,
    parameter int unsigned W           = 32,
    parameter int unsigned NUM_CLASSES = 4
) (
    input logic               clk,
    input logic               rst,
    hdc_assoc_search_if.slave bus
);
    localparam int unsigned WORDS = D / W;
    localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CW    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int unsigned DW    = $clog2(D + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_UPDATE,
        S_RESULT
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          re_q;
    logic          rvalid_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] cls_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] best_dist_q;
    logic [CW-1:0] best_cls_q;
    logic          res_valid_q;
    logic [CW-1:0] res_cls_q;
    logic [DW-1:0] res_dist_q;

    logic [W-1:0]  diff;
    logic [DW-1:0] pop_d;
    logic [DW-1:0] acc_d;
    logic          better_d;
    logic [DW-1:0] best_dist_d;
    logic [CW-1:0] best_cls_d;

    assign diff = bus.query_data ^ bus.class_data;

    always_comb begin
        pop_d = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pop_d = pop_d + DW'(diff[i]);
        end
    end

    assign acc_d = acc_q + pop_d;

    // Strict compare keeps the lower class index on ties.
    assign better_d    = acc_q < best_dist_q;
    assign best_dist_d = better_d ? acc_q : best_dist_q;
    assign best_cls_d  = better_d ? cls_q : best_cls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            re_q        <= 1'b0;
            rvalid_q    <= 1'b0;
            addr_q      <= '0;
            cls_q       <= '0;
            acc_q       <= '0;
            best_dist_q <= '0;
            best_cls_q  <= '0;
            res_valid_q <= 1'b0;
            res_cls_q   <= '0;
            res_dist_q  <= '0;
        end else begin
            // Memory data lands one cycle after each issued read.
            rvalid_q <= re_q;
            if (rvalid_q) begin
                acc_q <= acc_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q     <= S_READ;
                        busy_q      <= 1'b1;
                        re_q        <= 1'b1;
                        addr_q      <= '0;
                        cls_q       <= '0;
                        acc_q       <= '0;
                        best_dist_q <= '1;
                        best_cls_q  <= '0;
                    end
                end
                S_READ: begin
                    if (addr_q == AW'(WORDS - 1)) begin
                        state_q <= S_DRAIN;
                        re_q    <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    acc_q       <= '0;
                    best_dist_q <= best_dist_d;
                    best_cls_q  <= best_cls_d;
                    if (cls_q == CW'(NUM_CLASSES - 1)) begin
                        state_q     <= S_RESULT;
                        res_valid_q <= 1'b1;
                        res_cls_q   <= best_cls_d;
                        res_dist_q  <= best_dist_d;
                    end else begin
                        state_q <= S_READ;
                        cls_q   <= cls_q + 1'b1;
                        addr_q  <= '0;
                        re_q    <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (bus.result_ready) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    re_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.re           = re_q;
    assign bus.read_addr    = addr_q;
    assign bus.class_sel    = cls_q;
    assign bus.result_valid = res_valid_q;
    assign bus.result_class = res_cls_q;
    assign bus.result_dist  = res_dist_q;

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Directed bench for hdc_assoc_search: memory model with 1-cycle read latency and
// hand-computed winning class / distance per scenario.
module tb_hdc_assoc_search;
    localparam int unsigned D  = 128;
    localparam int unsigned W  = 32;
    localparam int unsigned NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hdc_assoc_search_if #(.D(D), .W(W), .NUM_CLASSES(NC)) bus ();

    hdc_assoc_search #(.D(D), .W(W), .NUM_CLASSES(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] qmem [4];
    logic [31:0] cmem [4][4];

    always @(posedge clk) begin
        if (bus.re) begin
            bus.query_data <= qmem[bus.read_addr];
            bus.class_data <= cmem[bus.class_sel][bus.read_addr];
        end else begin
            bus.query_data <= 32'hDEAD_BEEF;
            bus.class_data <= 32'h0;
        end
    end

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [127:0] q, input logic [127:0] c0, input logic [127:0] c1,
                        input logic [127:0] c2, input logic [127:0] c3);
        for (int i = 0; i < 4; i++) begin
            qmem[i]    = q[i*32 +: 32];
            cmem[0][i] = c0[i*32 +: 32];
            cmem[1][i] = c1[i*32 +: 32];
            cmem[2][i] = c2[i*32 +: 32];
            cmem[3][i] = c3[i*32 +: 32];
        end
    endtask

    // Pulse start, wait (bounded) for valid; returns cycle index of first valid.
    task automatic launch(input string tag, output int cyc);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_re"}, 32'(bus.re), 32'd1);
        cyc = 1;
        while (!bus.result_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic finish_handshake(input string tag);
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        check({tag, "_vld_off"}, 32'(bus.result_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_search(input string tag, input int exp_cls, input int exp_dist);
        int cyc;
        launch(tag, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'd25);
        check({tag, "_cls"}, 32'(bus.result_class), 32'(exp_cls));
        check({tag, "_dist"}, 32'(bus.result_dist), 32'(exp_dist));
        finish_handshake(tag);
    endtask

    localparam logic [127:0] Q   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] M32 = {96'h0, 32'hFFFF_FFFF};
    localparam logic [127:0] M64 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [127:0] M10 = {96'h0, 32'h0000_03FF};
    localparam logic [127:0] M50 = {64'h0, 32'h0003_FFFF, 32'hFFFF_FFFF};

    initial begin
        int cyc;
        int found;
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        load(Q, ~Q, Q ^ M32, Q, Q ^ M64);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_re", 32'(bus.re), 32'd0);
        check("rst_vld", 32'(bus.result_valid), 32'd0);
        check("rst_addr", 32'(bus.read_addr), 32'd0);
        check("rst_csel", 32'(bus.class_sel), 32'd0);
        check("rst_rdist", 32'(bus.result_dist), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: class 2 equals query; others at 128, 32, 64
        run_search("t1", 2, 0);

        // T2: tie at 10 between classes 1 and 3
        load(Q, Q ^ M50, Q ^ M10, Q ^ M50, Q ^ M10);
        run_search("t2", 1, 10);

        // T4: consumer stalls 5 cycles, start pulsed meanwhile
        load(Q, ~Q, Q ^ M32, Q, Q ^ M64);
        launch("t4", cyc);
        check("t4_lat", 32'(cyc), 32'd25);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            @(posedge clk); #1;
            check("t4_hold_vld", 32'(bus.result_valid), 32'd1);
            check("t4_hold_cls", 32'(bus.result_class), 32'd2);
            check("t4_hold_dist", 32'(bus.result_dist), 32'd0);
            check("t4_hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        finish_handshake("t4");
        @(posedge clk); #1;
        check("t4_noqueue", 32'(bus.busy), 32'd0);

        // T3: all distances equal D
        load('1, '0, '0, '0, '0);
        run_search("t3", 0, 128);

        // T5: reset while reading class 2
        load(Q, Q ^ M50, Q ^ M10, Q ^ M50, Q ^ M10);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (bus.class_sel == 2 && bus.re) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("t5_reach", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_re", 32'(bus.re), 32'd0);
        check("t5_vld", 32'(bus.result_valid), 32'd0);
        check("t5_rdist", 32'(bus.result_dist), 32'd0);
        check("t5_rcls", 32'(bus.result_class), 32'd0);
        check("t5_csel", 32'(bus.class_sel), 32'd0);
        @(posedge clk); #1;
        run_search("t5_rerun", 1, 10);

        // T6: start held high across two searches
        load(Q, ~Q, Q ^ M32, Q, Q ^ M64);
        bus.start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!bus.result_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6a_lat", 32'(cyc), 32'd25);
        check("t6a_cls", 32'(bus.result_class), 32'd2);
        check("t6a_dist", 32'(bus.result_dist), 32'd0);
        qmem[0] = ~Q[31:0];
        qmem[1] = ~Q[63:32];
        qmem[2] = Q[95:64];
        qmem[3] = Q[127:96];
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        check("t6_hs_idle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("t6b_restart", 32'(bus.busy), 32'd1);
        check("t6b_re", 32'(bus.re), 32'd1);
        cyc = 1;
        while (!bus.result_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("t6b_lat", 32'(cyc), 32'd25);
        check("t6b_cls", 32'(bus.result_class), 32'd3);
        check("t6b_dist", 32'(bus.result_dist), 32'd0);
        finish_handshake("t6b");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
